// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings, PC step, default NOP
// and the payload carried into the IF/ID pipeline register.
package fetch_stage_ctrl_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } ifIdPayload_t;

  // Sequential PC; the 32-bit add wraps 0xFFFF_FFFC to 0 by design.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats a new load, and an idle
// write slot turns into a bubble.
module if_id_reg
  import fetch_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         write_i,
  input  logic         load_i,
  input  ifIdPayload_t payload_i,
  output logic [31:0]  instr_o,
  output logic [31:0]  pcPlus4_o,
  output logic         valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;
  logic        valid_q, valid_d;

  // PCPlus4 is left alone on flush and bubble so downstream keeps a sane return address.
  always_comb begin
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!write_i) begin
      instr_d   = instr_q;
      pcPlus4_d = pcPlus4_q;
      valid_d   = valid_q;
    end else if (load_i) begin
      instr_d   = payload_i.instr;
      pcPlus4_d = payload_i.pcPlus4;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      pcPlus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcPlus4_o = pcPlus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC, runs a single-outstanding instruction-memory handshake,
// parks one response across stalls and feeds the IF/ID register.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        FetchBusy
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  bufData_q, bufData_d;
  logic         imemReq_q;
  logic [31:0]  imemAddr_q;
  logic         busy_q;
  logic         advance;
  logic         loadEn;
  ifIdPayload_t loadPayload;

  // A flush in the same cycle as a completing fetch must not consume the word.
  assign advance = PCWrite & IF_ID_Write & ~IF_ID_Flush;

  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    bufData_d           = bufData_q;
    loadEn              = 1'b0;
    loadPayload.instr   = ImemData;
    loadPayload.pcPlus4 = nextPc(pc_q);
    case (state_q)
      ST_FETCH: begin
        // The first FETCH after reset has not issued a request yet, so it lingers one cycle.
        if (Redirect) begin
          pc_d = RedirectPC;
        end else if (imemReq_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (Redirect) begin
          pc_d    = RedirectPC;
          state_d = ImemValid ? ST_FETCH : ST_DROP;
        end else if (ImemValid) begin
          if (advance) begin
            loadEn  = 1'b1;
            pc_d    = nextPc(pc_q);
            state_d = ST_FETCH;
          end else begin
            bufData_d = ImemData;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (Redirect) begin
          pc_d      = RedirectPC;
          bufData_d = 32'h0;
          state_d   = ST_FETCH;
        end else if (advance) begin
          loadEn            = 1'b1;
          loadPayload.instr = bufData_q;
          pc_d              = nextPc(pc_q);
          bufData_d         = 32'h0;
          state_d           = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The stale response still has to drain before a fresh request goes out.
        if (Redirect) begin
          pc_d = RedirectPC;
        end
        if (ImemValid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Handshake outputs are registered from the next state, keeping them free of input paths.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      bufData_q  <= 32'h0;
      imemReq_q  <= 1'b0;
      imemAddr_q <= 32'h0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bufData_q  <= bufData_d;
      imemReq_q  <= (state_d == ST_FETCH);
      imemAddr_q <= (state_d == ST_FETCH) ? pc_d : 32'h0;
      busy_q     <= (state_d == ST_WAIT) || (state_d == ST_DROP);
    end
  end

  assign ImemReq   = imemReq_q;
  assign ImemAddr  = imemAddr_q;
  assign FetchBusy = busy_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .flush_i  (IF_ID_Flush),
    .write_i  (IF_ID_Write),
    .load_i   (loadEn),
    .payload_i(loadPayload),
    .instr_o  (IF_ID_Instruction),
    .pcPlus4_o(IF_ID_PCPlus4),
    .valid_o  (IF_ID_Valid)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: each task drives one scenario and checks
// hand-computed IF/ID and handshake values.
module tb_fetch_stage_ctrl;

  logic        Clk;
  logic        Rst;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        FetchBusy;

  int compared;
  int mismatched;

  fetch_stage_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .Redirect         (Redirect),
    .RedirectPC       (RedirectPC),
    .ImemReq          (ImemReq),
    .ImemAddr         (ImemAddr),
    .ImemValid        (ImemValid),
    .ImemData         (ImemData),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .FetchBusy        (FetchBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    Redirect    = 1'b0;
    RedirectPC  = 32'h0;
    ImemValid   = 1'b0;
    ImemData    = 32'h0;
  endtask

  // Leaves the DUT one cycle after reset release: next edge issues the request at RESET_PC.
  task automatic doReset();
    idleInputs();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    compared++; if (ImemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req got %0b want 0", ImemReq); end
    compared++; if (ImemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_addr got %h want 0", ImemAddr); end
    compared++; if (FetchBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %0b want 0", FetchBusy); end
    compared++; if (IF_ID_Instruction !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr got %h want 0", IF_ID_Instruction); end
    compared++; if (IF_ID_PCPlus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pc4 got %h want 0", IF_ID_PCPlus4); end
    compared++; if (IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %0b want 0", IF_ID_Valid); end
    Rst = 1'b0;
  endtask

  task automatic test_streaming();
    doReset();
    tick();
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL stream_req0 got %0b/%h want 1/0", ImemReq, ImemAddr); end
    tick();
    compared++; if (ImemReq !== 1'b0 || FetchBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_wait0 got req %0b busy %0b want 0/1", ImemReq, FetchBusy); end
    ImemValid = 1'b1; ImemData = 32'h2010_0001;
    tick();
    ImemValid = 1'b0;
    compared++; if (IF_ID_Instruction !== 32'h2010_0001) begin mismatched++; $display("[TB] FAIL stream_instr got %h want 20100001", IF_ID_Instruction); end
    compared++; if (IF_ID_PCPlus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL stream_pc4 got %h want 4", IF_ID_PCPlus4); end
    compared++; if (IF_ID_Valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_valid got %0b want 1", IF_ID_Valid); end
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL stream_req4 got %0b/%h want 1/4", ImemReq, ImemAddr); end
    tick();
    compared++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0) begin mismatched++; $display("[TB] FAIL stream_bubble got %0b/%h want 0/0", IF_ID_Valid, IF_ID_Instruction); end
    ImemValid = 1'b1; ImemData = 32'h1111_2222;
    tick();
    ImemValid = 1'b0;
    compared++; if (IF_ID_Instruction !== 32'h1111_2222 || IF_ID_PCPlus4 !== 32'h8) begin mismatched++; $display("[TB] FAIL stream_second got %h/%h want 11112222/8", IF_ID_Instruction, IF_ID_PCPlus4); end
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin mismatched++; $display("[TB] FAIL stream_req8 got %0b/%h want 1/8", ImemReq, ImemAddr); end
  endtask

  task automatic test_stall_hold();
    doReset();
    tick();
    tick();
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    ImemValid = 1'b1; ImemData = 32'hAAAA_0001;
    tick();
    ImemValid = 1'b0;
    compared++; if (ImemReq !== 1'b0 || FetchBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_enter got req %0b busy %0b want 0/0", ImemReq, FetchBusy); end
    compared++; if (IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_ifid got %0b want 0", IF_ID_Valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++; if (ImemReq !== 1'b0 || IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_stall%0d got req %0b valid %0b want 0/0", i, ImemReq, IF_ID_Valid); end
    end
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    tick();
    compared++; if (IF_ID_Instruction !== 32'hAAAA_0001 || IF_ID_PCPlus4 !== 32'h4 || IF_ID_Valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_release got %h/%h/%0b want aaaa0001/4/1", IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid); end
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL hold_nextreq got %0b/%h want 1/4", ImemReq, ImemAddr); end
  endtask

  task automatic test_redirect_drop();
    doReset();
    tick();
    tick();
    Redirect = 1'b1; RedirectPC = 32'h40;
    tick();
    Redirect = 1'b0;
    compared++; if (FetchBusy !== 1'b1 || ImemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_enter got busy %0b req %0b want 1/0", FetchBusy, ImemReq); end
    tick();
    compared++; if (FetchBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_stay got %0b want 1", FetchBusy); end
    ImemValid = 1'b1; ImemData = 32'hDEAD_0001;
    tick();
    ImemValid = 1'b0;
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL drop_newreq got %0b/%h want 1/40", ImemReq, ImemAddr); end
    compared++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0) begin mismatched++; $display("[TB] FAIL drop_discard got %0b/%h want 0/0", IF_ID_Valid, IF_ID_Instruction); end
  endtask

  task automatic test_flush();
    doReset();
    tick();
    tick();
    ImemValid = 1'b1; ImemData = 32'h1234_5678;
    tick();
    ImemValid = 1'b0;
    IF_ID_Flush = 1'b1;
    tick();
    IF_ID_Flush = 1'b0;
    compared++; if (IF_ID_Instruction !== 32'h0 || IF_ID_Valid !== 1'b0 || IF_ID_PCPlus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL flush_nop got %h/%0b/%h want 0/0/4", IF_ID_Instruction, IF_ID_Valid, IF_ID_PCPlus4); end
    // Flush while the response completes: the word is parked, not lost.
    IF_ID_Flush = 1'b1; ImemValid = 1'b1; ImemData = 32'h0BAD_F00D;
    tick();
    IF_ID_Flush = 1'b0; ImemValid = 1'b0;
    compared++; if (FetchBusy !== 1'b0 || ImemReq !== 1'b0 || IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_park got busy %0b req %0b valid %0b want 0/0/0", FetchBusy, ImemReq, IF_ID_Valid); end
    tick();
    compared++; if (IF_ID_Instruction !== 32'h0BAD_F00D || IF_ID_PCPlus4 !== 32'h8 || IF_ID_Valid !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_unpark got %h/%h/%0b want 0badf00d/8/1", IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid); end
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin mismatched++; $display("[TB] FAIL flush_nextreq got %0b/%h want 1/8", ImemReq, ImemAddr); end
  endtask

  task automatic test_redirect_with_valid();
    doReset();
    tick();
    tick();
    Redirect = 1'b1; RedirectPC = 32'h100;
    ImemValid = 1'b1; ImemData = 32'h5555_0000;
    tick();
    Redirect = 1'b0; ImemValid = 1'b0;
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100 || FetchBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL rdv_req got %0b/%h busy %0b want 1/100/0", ImemReq, ImemAddr, FetchBusy); end
    compared++; if (IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rdv_discard got %0b want 0", IF_ID_Valid); end
    tick();
    ImemValid = 1'b1; ImemData = 32'h6666_0001;
    tick();
    ImemValid = 1'b0;
    compared++; if (IF_ID_Instruction !== 32'h6666_0001 || IF_ID_PCPlus4 !== 32'h104) begin mismatched++; $display("[TB] FAIL rdv_load got %h/%h want 66660001/104", IF_ID_Instruction, IF_ID_PCPlus4); end
  endtask

  task automatic test_pc_wrap();
    doReset();
    tick();
    tick();
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    ImemValid = 1'b1; ImemData = 32'h0;
    tick();
    Redirect = 1'b0; ImemValid = 1'b0;
    compared++; if (ImemAddr !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL wrap_addr got %h want fffffffc", ImemAddr); end
    tick();
    ImemValid = 1'b1; ImemData = 32'h7777_0007;
    tick();
    ImemValid = 1'b0;
    compared++; if (IF_ID_PCPlus4 !== 32'h0 || IF_ID_Instruction !== 32'h7777_0007) begin mismatched++; $display("[TB] FAIL wrap_pc4 got %h/%h want 0/77770007", IF_ID_PCPlus4, IF_ID_Instruction); end
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_next got %0b/%h want 1/0", ImemReq, ImemAddr); end
  endtask

  task automatic test_async_reset();
    doReset();
    tick();
    tick();
    ImemValid = 1'b1; ImemData = 32'h3030_0003;
    tick();
    ImemValid = 1'b0;
    tick();
    #2;
    Rst = 1'b1;
    #1;
    compared++; if (FetchBusy !== 1'b0 || ImemReq !== 1'b0 || ImemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL areset_hs got busy %0b req %0b addr %h want 0/0/0", FetchBusy, ImemReq, ImemAddr); end
    compared++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0 || IF_ID_PCPlus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL areset_ifid got %0b/%h/%h want 0/0/0", IF_ID_Valid, IF_ID_Instruction, IF_ID_PCPlus4); end
    tick();
    Rst = 1'b0;
    ImemValid = 1'b1; ImemData = 32'hBAD0_BAD0;
    tick();
    ImemValid = 1'b0;
    compared++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || FetchBusy !== 1'b0 || IF_ID_Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_stray got req %0b addr %h busy %0b valid %0b want 1/0/0/0", ImemReq, ImemAddr, FetchBusy, IF_ID_Valid); end
    tick();
    compared++; if (FetchBusy !== 1'b1 || ImemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_resume got busy %0b req %0b want 1/0", FetchBusy, ImemReq); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst        = 1'b1;
    idleInputs();
    test_reset();
    test_streaming();
    test_stall_hold();
    test_redirect_drop();
    test_flush();
    test_redirect_with_valid();
    test_pc_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
